// File: rtl/bru_pkg.sv
// Shared constants for the branch resolve unit: widths and
// branch condition encodings.
package bru_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // {valid, pc, bpred, bpred_valid}
    localparam int IFID_W = 1 + XLEN + 2;
    // {valid, pc, bpred, bpred_valid, is_branch, target, funct3}
    localparam int IDEX_W = 1 + XLEN + 2 + 1 + XLEN + 3;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: funct3 and the two operands
// in, taken condition out.
module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            cond_o
);
    import bru_pkg::*;

    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            BEQ:     cond_o = (rs1_i == rs2_i);
            BNE:     cond_o = (rs1_i != rs2_i);
            BLT:     cond_o = ($signed(rs1_i) <  $signed(rs2_i));
            BGE:     cond_o = ($signed(rs1_i) >= $signed(rs2_i));
            BLTU:    cond_o = (rs1_i <  rs2_i);
            BGEU:    cond_o = (rs1_i >= rs2_i);
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch-time predictions to EX, resolves branches there,
// redirects fetch on mispredicts and keeps branch statistics.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_bpred,
    input  logic            if_bpred_valid,
    input  logic            id_is_branch,
    input  logic [XLEN-1:0] id_target,
    input  logic [2:0]      id_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic            ID_EX_BPred,
    output logic            ID_EX_BPredValid,
    output logic            PCSrc,
    output logic [XLEN-1:0] PC_Branch,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    import bru_pkg::*;

    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q;
    logic            ifid_bpred_q;
    logic            ifid_bpv_q;
    logic            ifid_load;

    logic            idex_valid_q, idex_valid_d;
    logic [XLEN-1:0] idex_pc_q;
    logic            idex_bpred_q;
    logic            idex_bpv_q;
    logic            idex_isbr_q;
    logic [XLEN-1:0] idex_target_q;
    logic [2:0]      idex_funct3_q;

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic            cond;
    logic            ex_br;
    logic            pt;
    logic            br_mis;
    logic            alias_mis;
    logic            redir;
    logic [XLEN-1:0] pc_plus4;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3_i (idex_funct3_q),
        .rs1_i    (ex_rs1),
        .rs2_i    (ex_rs2),
        .cond_o   (cond)
    );

    assign ex_br     = idex_valid_q & idex_isbr_q;
    assign pt        = idex_bpv_q & idex_bpred_q;
    assign br_mis    = ex_br & (cond != pt);
    assign alias_mis = idex_valid_q & ~idex_isbr_q & pt;
    assign redir     = br_mis | alias_mis;
    assign pc_plus4  = idex_pc_q + XLEN'(4);

    assign ID_EX_PC         = idex_valid_q ? idex_pc_q : '0;
    assign ID_EX_BPred      = idex_valid_q & idex_bpred_q;
    assign ID_EX_BPredValid = ex_br & idex_bpv_q;
    assign PCSrc            = ex_br & cond;
    assign PC_Branch        = idex_valid_q ? idex_target_q : '0;
    assign redirect_valid   = redir;
    assign flush            = redir;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mis_cnt_q;

    // A branch that resolves taken goes to its target, anything
    // else falls through, including aliased non-branches.
    always_comb begin
        redirect_pc = '0;
        if (idex_valid_q)
            redirect_pc = (ex_br & cond) ? idex_target_q : pc_plus4;
    end

    // Flush beats stall: a held IF/ID slot is wrong-path anyway.
    always_comb begin
        ifid_valid_d = if_valid;
        idex_valid_d = ifid_valid_q;
        ifid_load    = 1'b1;
        if (redir) begin
            ifid_valid_d = 1'b0;
            idex_valid_d = 1'b0;
        end else if (stall) begin
            ifid_valid_d = ifid_valid_q;
            idex_valid_d = 1'b0;
            ifid_load    = 1'b0;
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (ex_br && br_cnt_q != '1)
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (redir && mis_cnt_q != '1)
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            idex_valid_q <= 1'b0;
            br_cnt_q     <= '0;
            mis_cnt_q    <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            idex_valid_q <= idex_valid_d;
            br_cnt_q     <= br_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ifid_load) begin
            ifid_pc_q    <= if_pc;
            ifid_bpred_q <= if_bpred;
            ifid_bpv_q   <= if_bpred_valid;
        end
        idex_pc_q     <= ifid_pc_q;
        idex_bpred_q  <= ifid_bpred_q;
        idex_bpv_q    <= ifid_bpv_q;
        idex_isbr_q   <= id_is_branch;
        idex_target_q <= id_target;
        idex_funct3_q <= id_funct3;
    end

endmodule
